// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings and types for the fetch-stage controller.
// NPC_* codes match the existing next-PC mux and trace logic.
package pc_fetch_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NPC_W = 3;

  localparam logic [NPC_W-1:0] NPC_PLUS4  = 3'b000;
  localparam logic [NPC_W-1:0] NPC_BRANCH = 3'b001;
  localparam logic [NPC_W-1:0] NPC_JUMP   = 3'b010;
  localparam logic [NPC_W-1:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_STALL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  target;
    logic [NPC_W-1:0] op;
  } redirect_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority select of the next-PC redirect (EX > stall > ID JAL) plus the
// pending-redirect register used while a fetch is still outstanding.
module pc_redirect_arb
  import pc_fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             ack_cycle,
  input  logic             wait_cycle,
  input  logic             can_move,
  input  logic             stall,
  input  logic             id_jal,
  input  logic [XLEN-1:0]  id_target,
  input  logic             ex_redirect,
  input  logic             ex_is_jalr,
  input  logic [XLEN-1:0]  ex_target,
  output logic             take_valid,
  output logic [XLEN-1:0]  take_target,
  output logic [NPC_W-1:0] npc_op,
  output logic             flush_ifid,
  output logic             flush_idex
);

  redirect_t pend_q;
  redirect_t pend_d;
  redirect_t ex_req;
  redirect_t id_req;
  redirect_t sel;
  logic      ex_take;
  logic      id_take;
  logic      pend_is_ex;

  // A pending EX redirect already squashed ID, so a JAL seen there is wrong-path.
  assign pend_is_ex = pend_q.valid && (pend_q.op != NPC_JUMP);
  assign ex_take    = en && ex_redirect;
  assign id_take    = en && id_jal && !ex_redirect && !stall && !pend_is_ex;

  assign ex_req = '{valid: 1'b1, target: ex_target,
                    op: (ex_is_jalr ? NPC_JALR : NPC_BRANCH)};
  assign id_req = '{valid: 1'b1, target: id_target, op: NPC_JUMP};

  always_comb begin
    sel = '0;
    if (ex_take) begin
      sel = ex_req;
    end else if (id_take) begin
      sel = id_req;
    end else if (ack_cycle && pend_q.valid) begin
      sel = pend_q;
    end
  end

  assign take_valid  = can_move && sel.valid;
  assign take_target = sel.target & ~XLEN'(3);
  assign npc_op      = sel.valid ? sel.op : NPC_PLUS4;
  assign flush_ifid  = ex_take || id_take;
  assign flush_idex  = ex_take;

  always_comb begin
    pend_d = pend_q;
    if (ack_cycle) begin
      pend_d = '0;
    end else if (wait_cycle && (ex_take || id_take)) begin
      pend_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: PC register, imem req/ack FSM, redirect/flush control.
// Optional perf counters enabled by defining PC_FETCH_PERF_CNT_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              id_jal,
  input  logic [31:0]       id_target,
  input  logic              ex_redirect,
  input  logic              ex_is_jalr,
  input  logic [31:0]       ex_target,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  output logic              if_valid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [2:0]        npc_op
`ifdef PC_FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_fetch,
  output logic [CNT_W-1:0]  cnt_redirect,
  output logic [CNT_W-1:0]  cnt_stall
`endif
);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("pc_fetch_ctrl: CNT_W must be non-zero");
  end

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  logic            arb_en;
  logic            ack_cycle;
  logic            wait_cycle;
  logic            can_move;
  logic            take_valid;
  logic [XLEN-1:0] take_target;

  // Cycle qualifiers depend only on state and ack, keeping the arbiter loop-free.
  assign arb_en     = (state_q == S_REQ) || (state_q == S_STALL);
  assign ack_cycle  = (state_q == S_REQ) && imem_ack;
  assign wait_cycle = (state_q == S_REQ) && !imem_ack;
  assign can_move   = ack_cycle || (state_q == S_STALL);
  assign imem_addr  = pc_q;

  pc_redirect_arb u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .en          (arb_en),
    .ack_cycle   (ack_cycle),
    .wait_cycle  (wait_cycle),
    .can_move    (can_move),
    .stall       (stall),
    .id_jal      (id_jal),
    .id_target   (id_target),
    .ex_redirect (ex_redirect),
    .ex_is_jalr  (ex_is_jalr),
    .ex_target   (ex_target),
    .take_valid  (take_valid),
    .take_target (take_target),
    .npc_op      (npc_op),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    if_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (take_valid) begin
            pc_d = take_target;
          end else if (stall) begin
            state_d = S_STALL;
          end else begin
            if_valid = 1'b1;
            pc_d     = pc_q + XLEN'(4);
          end
        end
      end
      S_STALL: begin
        if (take_valid) begin
          pc_d    = take_target;
          state_d = S_REQ;
        end else if (!stall) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef PC_FETCH_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_fetch    <= '0;
      cnt_redirect <= '0;
      cnt_stall    <= '0;
    end else begin
      if (if_valid && (cnt_fetch != '1))      cnt_fetch    <= cnt_fetch + CNT_W'(1);
      if (flush_ifid && (cnt_redirect != '1)) cnt_redirect <= cnt_redirect + CNT_W'(1);
      if (stall && (cnt_stall != '1))         cnt_stall    <= cnt_stall + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl (RESET_PC=0x100).
// With PC_FETCH_PERF_CNT_EN defined, also checks 4-bit counter saturation.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        id_jal;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic        ex_is_jalr;
  logic [31:0] ex_target;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic [2:0]  npc_op;
`ifdef PC_FETCH_PERF_CNT_EN
  logic [3:0]  cnt_fetch;
  logic [3:0]  cnt_redirect;
  logic [3:0]  cnt_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_PC (32'h0000_0100)
`ifdef PC_FETCH_PERF_CNT_EN
    , .CNT_W  (4)
`endif
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .id_jal       (id_jal),
    .id_target    (id_target),
    .ex_redirect  (ex_redirect),
    .ex_is_jalr   (ex_is_jalr),
    .ex_target    (ex_target),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .if_valid     (if_valid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .npc_op       (npc_op)
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    .cnt_fetch    (cnt_fetch),
    .cnt_redirect (cnt_redirect),
    .cnt_stall    (cnt_stall)
`endif
  );

  typedef struct {
    logic        rstn;
    logic        stall;
    logic        id_jal;
    logic [31:0] id_target;
    logic        ex_redirect;
    logic        ex_is_jalr;
    logic [31:0] ex_target;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic        e_fi;
    logic        e_fe;
    logic [2:0]  e_op;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic st, input logic jal,
                              input logic [31:0] idt, input logic exr, input logic jr,
                              input logic [31:0] ext, input logic ack,
                              input logic req, input logic [31:0] addr, input logic ifv,
                              input logic fi, input logic fe, input logic [2:0] op);
    vec_t v;
    v.rstn = r; v.stall = st; v.id_jal = jal; v.id_target = idt;
    v.ex_redirect = exr; v.ex_is_jalr = jr; v.ex_target = ext; v.ack = ack;
    v.e_req = req; v.e_addr = addr; v.e_ifv = ifv; v.e_fi = fi; v.e_fe = fe; v.e_op = op;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row%0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic jal, input logic [31:0] idt,
                       input logic exr, input logic jr, input logic [31:0] ext,
                       input logic ack);
    rstn = r; stall = st; id_jal = jal; id_target = idt;
    ex_redirect = exr; ex_is_jalr = jr; ex_target = ext; imem_ack = ack;
  endtask

  initial begin
    // rstn st jal idt exr jr ext ack | req addr ifv fi fe op
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 0,32'h100,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 0,32'h100,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h100,1,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h104,1,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,1,0,32'h200,1, 1,32'h108,0,1,1,NPC_BRANCH));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,32'h200,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h200,1,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,1,32'h300,0,0,0,0, 1,32'h204,0,1,0,NPC_JUMP));
    vecs.push_back(mk(1,0,0,0,1,1,32'h403,0, 1,32'h204,0,1,1,NPC_JALR));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,32'h204,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h204,0,0,0,NPC_JALR));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h400,1,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,1,0,32'h120,1, 1,32'h404,0,1,1,NPC_BRANCH));
    vecs.push_back(mk(1,1,0,0,0,0,0,1, 1,32'h120,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,1,0,0,0,0,0,1, 0,32'h120,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 0,32'h120,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h120,1,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,1,1,32'h500,0,0,0,1, 1,32'h124,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,1,1,32'h500,0,0,0,0, 0,32'h124,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,1,1,32'h500,1,0,32'h600,0, 0,32'h124,0,1,1,NPC_BRANCH));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h600,1,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,1,1,32'hFFFF_FFFF,1, 1,32'h604,0,1,1,NPC_JALR));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'hFFFF_FFFC,1,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,32'h0,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h0,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 0,32'h100,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,32'h100,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,1,0,32'h700,0, 1,32'h100,0,1,1,NPC_BRANCH));
    vecs.push_back(mk(1,0,1,32'h800,0,0,0,0, 1,32'h100,0,0,0,NPC_PLUS4));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h100,0,0,0,NPC_BRANCH));
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 1,32'h700,1,0,0,NPC_PLUS4));

    drive(0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rstn, vecs[i].stall, vecs[i].id_jal, vecs[i].id_target,
            vecs[i].ex_redirect, vecs[i].ex_is_jalr, vecs[i].ex_target, vecs[i].ack);
      #1;
      check("imem_req",   i, 32'(imem_req),   32'(vecs[i].e_req));
      check("imem_addr",  i, imem_addr,       vecs[i].e_addr);
      check("if_valid",   i, 32'(if_valid),   32'(vecs[i].e_ifv));
      check("flush_ifid", i, 32'(flush_ifid), 32'(vecs[i].e_fi));
      check("flush_idex", i, 32'(flush_idex), 32'(vecs[i].e_fe));
      check("npc_op",     i, 32'(npc_op),     32'(vecs[i].e_op));
    end

    // Stall without ack keeps the request up at the same address.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1,1,0,0,0,0,0,0);
      #1;
      check("hold_req",  100 + k, 32'(imem_req), 32'd1);
      check("hold_addr", 100 + k, imem_addr, 32'h704);
    end
    @(negedge clk);
    drive(1,1,0,0,0,0,0,1);
    #1;
    check("stall_ack_ifv", 110, 32'(if_valid), 32'd0);
    @(negedge clk);
    drive(1,0,0,0,0,0,0,1);
    #1;
    check("stall_state_req", 111, 32'(imem_req), 32'd0);
    @(negedge clk);
    drive(1,0,0,0,0,0,0,1);
    #1;
    check("refetch_addr", 112, imem_addr, 32'h704);
    check("refetch_ifv",  112, 32'(if_valid), 32'd1);

`ifdef PC_FETCH_PERF_CNT_EN
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0);
    @(negedge clk);
    drive(1,0,0,0,0,0,0,1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1,0,0,0,0,0,0,1);
    end
    @(negedge clk);
    drive(1,1,0,0,0,0,0,0);
    #1;
    check("cnt_fetch_sat", 120, 32'(cnt_fetch),    32'd15);
    check("cnt_redirect",  120, 32'(cnt_redirect), 32'd0);
    check("cnt_stall0",    120, 32'(cnt_stall),    32'd0);
    repeat (2) begin
      @(negedge clk);
      drive(1,1,0,0,0,0,0,0);
    end
    @(negedge clk);
    drive(1,0,0,0,0,0,0,0);
    #1;
    check("cnt_stall3", 121, 32'(cnt_stall), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
